// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Two-requester write arbiter in front of a 32-entry register-file write port.
// It also runs a zeroing sweep over registers 1..31, either on ClearStart or
// automatically after reset when CLEAR_ON_RESET=1.
// Optional feature: define REGFILE_WRITE_ARBITER_COUNT_EN to add a saturating
// 16-bit WriteCount output that counts cycles with RegWrite=1.
`timescale 1ns/1ps

module regfile_write_arbiter #(
   parameter int CLEAR_ON_RESET = 1,
   parameter int DATA_WIDTH     = 32
) (
   input  logic                  Clock,
   input  logic                  Reset_n,
   input  logic                  Req0Valid,
   input  logic                  Req1Valid,
   input  logic [4:0]            Req0Reg,
   input  logic [4:0]            Req1Reg,
   input  logic [DATA_WIDTH-1:0] Req0Data,
   input  logic [DATA_WIDTH-1:0] Req1Data,
   output logic                  Req0Ready,
   output logic                  Req1Ready,
   input  logic                  ClearStart,
   output logic                  Busy,
   output logic                  RegWrite,
   output logic [4:0]            WriteRegister,
   output logic [DATA_WIDTH-1:0] WriteData
`ifdef REGFILE_WRITE_ARBITER_COUNT_EN
   ,
   output logic [15:0]           WriteCount
`endif
);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t     state;
   logic       last_grant;    // 0: Req0 won the last accepted transfer, 1: Req1
   logic [4:0] clear_idx;
   logic       auto_pend;     // one-shot: start a sweep on the first edge after reset
   logic       start_clear;
   logic       grant0;
   logic       grant1;

   // Grant decode: clear wins, then a lone requester, then round-robin on a tie.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      grant0      = 1'b0;
      grant1      = 1'b0;
      start_clear = (state == IDLE) && (ClearStart || auto_pend);
      if (Reset_n && (state == IDLE) && !start_clear) begin
         if (Req0Valid && (!Req1Valid || last_grant))
            grant0 = 1'b1;
         else if (Req1Valid)
            grant1 = 1'b1;
      end
   end

   assign Req0Ready = grant0;
   assign Req1Ready = grant1;
   assign Busy      = (state == CLEAR);

   // Sweep FSM with registered write-port outputs; accepted requests land one cycle later.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         clear_idx     <= 5'd1;
         auto_pend     <= (CLEAR_ON_RESET != 0);
         RegWrite      <= 1'b0;
         WriteRegister <= 5'd0;
         WriteData     <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples pre-edge values regardless of statement order.
         auto_pend <= 1'b0;
         RegWrite  <= 1'b0;
         case (state)
            IDLE: begin
               if (start_clear) begin
                  state     <= CLEAR;
                  clear_idx <= 5'd1;
               end else if (grant0) begin
                  last_grant <= 1'b0;
                  if (Req0Reg != 5'd0) begin
                     RegWrite      <= 1'b1;
                     WriteRegister <= Req0Reg;
                     WriteData     <= Req0Data;
                  end
               end else if (grant1) begin
                  last_grant <= 1'b1;
                  if (Req1Reg != 5'd0) begin
                     RegWrite      <= 1'b1;
                     WriteRegister <= Req1Reg;
                     WriteData     <= Req1Data;
                  end
               end
            end
            CLEAR: begin
               RegWrite      <= 1'b1;
               WriteRegister <= clear_idx;
               WriteData     <= '0;
               if (clear_idx == 5'd31) begin
                  state     <= IDLE;
                  clear_idx <= 5'd1;
               end else begin
                  clear_idx <= clear_idx + 5'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef REGFILE_WRITE_ARBITER_COUNT_EN
   // Saturating count of cycles on which the write port is active.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n)
         WriteCount <= 16'd0;
      else if (RegWrite && (WriteCount != 16'hFFFF))
         WriteCount <= WriteCount + 16'd1;
   end
`endif

endmodule
